vn_serial_proc: RTL and testbench

- Serial, parametrised variable-node processor for the LDPC QKD decoder. Generalises the fixed degree-7 combinational node to any degree up to DEG_MAX, selected per node at run time.
- Accepts one channel LLR plus up to DEG_MAX check-to-variable messages streamed one per cycle, then streams back the extrinsic variable-to-check messages. Also produces the a-posteriori belief and the hard decision.
- Sits between the check-message memory and the VN-to-CN message router. One instance is time-shared over many variable nodes.

---
 rtl/vn_pkg.sv | 30 +++
 rtl/vn_sat_clamp.sv | 28 ++
 rtl/vn_serial_proc.sv | 165 ++++++++++++++++
 tb/tb_vn_serial_proc.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vn_pkg.sv
// Shared types and constants for the serial variable-node processor.
// Symmetric saturation bounds, message type, FSM state encoding.
package vn_pkg;

  localparam int INT     = 8;
  localparam int FRAC    = 8;
  localparam int W       = INT + FRAC;
  localparam int DEG_MAX = 16;
  localparam int ACC_W   = W + $clog2(DEG_MAX + 2);

  typedef logic signed [W-1:0] msg_t;

  // -2^(W-1) is excluded so that negation never overflows
  localparam msg_t MSG_MAX = msg_t'((2 ** (W - 1)) - 1);
  localparam msg_t MSG_MIN = -MSG_MAX;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SUM,
    EMIT
  } state_t;

  function automatic msg_t sat_w(input logic signed [ACC_W-1:0] wide);
    if (wide > ACC_W'(MSG_MAX)) return MSG_MAX;
    if (wide < ACC_W'(MSG_MIN)) return MSG_MIN;
    return wide[W-1:0];
  endfunction

endpackage

// File: rtl/vn_sat_clamp.sv
// Wide-to-narrow symmetric saturate, optionally tightened to +/-CLIP_MAG.
// Latency: combinational. Backpressure: none (pure function of its input).
// Clamping to min(sat limit, CLIP_MAG) equals saturate-then-clip.
module vn_sat_clamp #(
  parameter int IN_W     = 21,
  parameter int OUT_W    = 16,
  parameter int CLIP_EN  = 0,
  parameter int CLIP_MAG = 16384
) (
  input  logic signed [IN_W-1:0]  in_val,
  output logic signed [OUT_W-1:0] out_val
);

  localparam int SAT_LIM = (2 ** (OUT_W - 1)) - 1;
  localparam int LIM     = ((CLIP_EN != 0) && (CLIP_MAG < SAT_LIM)) ? CLIP_MAG : SAT_LIM;
  localparam logic signed [IN_W-1:0] HI = IN_W'(LIM);
  localparam logic signed [IN_W-1:0] LO = -HI;

  always_comb begin
    out_val = in_val[OUT_W-1:0];
    if (in_val > HI) begin
      out_val = HI[OUT_W-1:0];
    end else if (in_val < LO) begin
      out_val = LO[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/vn_serial_proc.sv
// Serial variable-node processor (optional VN_MSG_CLIP_EN clips outgoing messages).
// Latency: belief_valid and first vr_valid two cycles after the last check message.
// Backpressure: vr_* held stable while vr_ready is low; ch_ready only in LOAD.
module vn_serial_proc
  import vn_pkg::*;
#(
  parameter int INT      = 8,
  parameter int FRAC     = 8,
  parameter int DEG_MAX  = 16,
  parameter int CLIP_MAG = 2 ** (INT + FRAC - 2)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [INT+FRAC-1:0]            llr,
  input  logic [$clog2(DEG_MAX+1)-1:0]   deg,
  output logic                           busy,
  input  logic                           ch_valid,
  output logic                           ch_ready,
  input  logic [INT+FRAC-1:0]            ch_msg,
  output logic                           vr_valid,
  input  logic                           vr_ready,
  output logic [INT+FRAC-1:0]            vr_msg,
  output logic [$clog2(DEG_MAX)-1:0]     vr_idx,
  output logic                           vr_last,
  output logic [INT+FRAC-1:0]            belief,
  output logic                           hard_bit,
  output logic                           belief_valid
);

  localparam int MW = INT + FRAC;
  localparam int DW = $clog2(DEG_MAX + 1);
  localparam int IW = $clog2(DEG_MAX);
  localparam int AW = MW + $clog2(DEG_MAX + 2);

`ifdef VN_MSG_CLIP_EN
  localparam int MSG_CLIP = 1;
`else
  localparam int MSG_CLIP = 0;
`endif

  state_t                state_q, state_d;
  logic [DW-1:0]         deg_q, deg_d;
  logic [DW-1:0]         cnt_q, cnt_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [MW-1:0]  buf_q [DEG_MAX];
  logic signed [MW-1:0]  buf_d [DEG_MAX];
  logic signed [MW-1:0]  belief_q, belief_d;
  logic                  hard_q, hard_d;
  logic                  bvld_q, bvld_d;

  logic signed [MW-1:0]  acc_sat;
  logic signed [MW-1:0]  ext_sat;
  logic signed [AW-1:0]  ext_wide;
  logic [IW-1:0]         idx;
  logic                  at_last;

  // The most negative code is folded onto -(2^(MW-1)-1) to keep the range symmetric
  function automatic logic signed [MW-1:0] norm_in(input logic [MW-1:0] x);
    if (x == {1'b1, {(MW-1){1'b0}}}) return {1'b1, {(MW-2){1'b0}}, 1'b1};
    return x;
  endfunction

  assign idx      = cnt_q[IW-1:0];
  assign at_last  = (cnt_q == deg_q - DW'(1));
  assign ext_wide = acc_q - AW'(buf_q[idx]);

  vn_sat_clamp #(
    .IN_W    (AW),
    .OUT_W   (MW),
    .CLIP_EN (0),
    .CLIP_MAG(CLIP_MAG)
  ) u_sat_belief (
    .in_val (acc_q),
    .out_val(acc_sat)
  );

  vn_sat_clamp #(
    .IN_W    (AW),
    .OUT_W   (MW),
    .CLIP_EN (MSG_CLIP),
    .CLIP_MAG(CLIP_MAG)
  ) u_sat_msg (
    .in_val (ext_wide),
    .out_val(ext_sat)
  );

  always_comb begin
    state_d  = state_q;
    deg_d    = deg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    buf_d    = buf_q;
    belief_d = belief_q;
    hard_d   = hard_q;
    bvld_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          deg_d   = (deg > DW'(DEG_MAX)) ? DW'(DEG_MAX) : deg;
          acc_d   = AW'(norm_in(llr));
          cnt_d   = '0;
          state_d = (deg == '0) ? SUM : LOAD;
        end
      end
      LOAD: begin
        if (ch_valid) begin
          buf_d[idx] = norm_in(ch_msg);
          acc_d      = acc_q + AW'(norm_in(ch_msg));
          cnt_d      = cnt_q + DW'(1);
          if (cnt_d == deg_q) state_d = SUM;
        end
      end
      SUM: begin
        belief_d = acc_sat;
        hard_d   = acc_sat[MW-1];
        bvld_d   = 1'b1;
        cnt_d    = '0;
        state_d  = (deg_q == '0) ? IDLE : EMIT;
      end
      EMIT: begin
        if (vr_ready) begin
          if (at_last) state_d = IDLE;
          else         cnt_d   = cnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      deg_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      belief_q <= '0;
      hard_q   <= 1'b0;
      bvld_q   <= 1'b0;
      for (int i = 0; i < DEG_MAX; i++) buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      deg_q    <= deg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      belief_q <= belief_d;
      hard_q   <= hard_d;
      bvld_q   <= bvld_d;
      for (int i = 0; i < DEG_MAX; i++) buf_q[i] <= buf_d[i];
    end
  end

  // Message outputs are forced to zero outside EMIT so reset clears them too
  assign busy         = (state_q != IDLE);
  assign ch_ready     = (state_q == LOAD);
  assign vr_valid     = (state_q == EMIT);
  assign vr_msg       = vr_valid ? ext_sat : '0;
  assign vr_idx       = vr_valid ? idx : '0;
  assign vr_last      = vr_valid && at_last;
  assign belief       = belief_q;
  assign hard_bit     = hard_q;
  assign belief_valid = bvld_q;

endmodule

// File: tb/tb_vn_serial_proc.sv
// Scoreboard bench for vn_serial_proc: model results queued at stimulus time, popped on DUT output.
module tb_vn_serial_proc;

`ifdef VN_MSG_CLIP_EN
  localparam int TB_CLIP = 'h0300;
`else
  localparam int TB_CLIP = 'h4000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] llr = '0;
  logic [4:0]  deg = '0;
  logic        busy;
  logic        ch_valid = 1'b0;
  logic        ch_ready;
  logic [15:0] ch_msg = '0;
  logic        vr_valid;
  logic        vr_ready = 1'b1;
  logic [15:0] vr_msg;
  logic [3:0]  vr_idx;
  logic        vr_last;
  logic [15:0] belief;
  logic        hard_bit;
  logic        belief_valid;

  vn_serial_proc #(.CLIP_MAG(TB_CLIP)) dut (
    .clk(clk), .rst(rst), .start(start), .llr(llr), .deg(deg), .busy(busy),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_msg(ch_msg),
    .vr_valid(vr_valid), .vr_ready(vr_ready), .vr_msg(vr_msg), .vr_idx(vr_idx),
    .vr_last(vr_last), .belief(belief), .hard_bit(hard_bit), .belief_valid(belief_valid)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_acc = 0;
  logic [15:0] stim[$];
  logic [15:0] bq[$];
  logic [20:0] vq[$];
  bit          bp_arm = 1'b0;
  logic [15:0] bp_exp = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat16(input int x);
    if (x > 32767) return 32767;
    if (x < -32767) return -32767;
    return x;
  endfunction

  function automatic int nrm(input logic [15:0] x);
    int s;
    s = int'($signed(x));
    return (s == -32768) ? -32767 : s;
  endfunction

  task automatic expect_node(input logic [15:0] l, input int d);
    int n, tot, v;
    n = (d > 16) ? 16 : d;
    tot = nrm(l);
    for (int i = 0; i < n; i++) tot += nrm(stim[i]);
    bq.push_back(16'(sat16(tot)));
    for (int i = 0; i < n; i++) begin
      v = sat16(tot - nrm(stim[i]));
`ifdef VN_MSG_CLIP_EN
      if (v > TB_CLIP) v = TB_CLIP;
      if (v < -TB_CLIP) v = -TB_CLIP;
`endif
      vq.push_back({(i == n - 1), 4'(i), 16'(v)});
    end
  endtask

  task automatic start_node(input logic [15:0] l, input logic [4:0] d);
    @(posedge clk); #1;
    start = 1'b1; llr = l; deg = d;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input bit keep);
    for (int i = 0; i < n; i++) begin
      bit got;
      int guard;
      got = 1'b0; guard = 0;
      ch_valid = 1'b1; ch_msg = stim[i];
      while (!got && guard < 100) begin
        @(negedge clk); got = ch_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!got) chk("ch_accept_timeout", 0, 1);
    end
    if (!keep) ch_valid = 1'b0;
  endtask

  task automatic check_latency();
    @(negedge clk);
    chk("sum_bvld", belief_valid, 0);
    chk("sum_ch_ready", ch_ready, 0);
    chk("sum_busy", busy, 1);
    @(negedge clk);
    chk("lat_bvld", belief_valid, 1);
    chk("lat_vr_valid", vr_valid, 1);
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (busy && g < 500) begin @(negedge clk); g++; end
    chk(tag, busy, 0);
    chk("vr_left", vq.size(), 0);
    chk("belief_left", bq.size(), 0);
  endtask

  task automatic run_node(input logic [15:0] l, input int d, input bit keep);
    int n;
    n = (d > 16) ? 16 : d;
    expect_node(l, d);
    start_node(l, 5'(d));
    feed(n, keep);
    if (n > 0) check_latency();
    wait_idle("idle_timeout");
  endtask

  // Output monitor: every belief pulse and vr transfer must match the model queue
  initial forever begin
    @(negedge clk);
    if (ch_valid && ch_ready) n_acc++;
    if (belief_valid) begin
      if (bq.size() == 0) chk("belief_extra", 1, 0);
      else begin
        logic [15:0] e;
        e = bq.pop_front();
        chk("belief", belief, e);
        chk("hard_bit", hard_bit, e[15]);
      end
    end
    if (vr_valid && vr_ready) begin
      if (vq.size() == 0) chk("vr_extra", 1, 0);
      else begin
        logic [20:0] e;
        e = vq.pop_front();
        chk("vr_msg", vr_msg, e[15:0]);
        chk("vr_idx", vr_idx, e[19:16]);
        chk("vr_last", vr_last, e[20]);
      end
    end
  end

  // Stall vr_ready for three cycles while edge 1 is presented
  initial forever begin
    @(negedge clk);
    if (bp_arm && vr_valid && vr_ready && vr_idx == 4'd0) begin
      bp_arm = 1'b0;
      @(posedge clk); #1;
      vr_ready = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("bp_valid", vr_valid, 1);
        chk("bp_msg", vr_msg, bp_exp);
        chk("bp_idx", vr_idx, 1);
      end
      @(posedge clk); #1;
      vr_ready = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_ch_ready", ch_ready, 0);
    chk("rst_vr_valid", vr_valid, 0);
    chk("rst_belief", belief, 0);
    chk("rst_bvld", belief_valid, 0);
    chk("rst_hard", hard_bit, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Nominal
    stim = '{16'h0200, 16'hFF00, 16'h0080};
    run_node(16'h0100, 3, 1'b0);

    // Saturation, then the most negative input code
    stim = '{16'h7000, 16'h7000};
    run_node(16'h7000, 2, 1'b0);
    stim = '{16'h8000};
    run_node(16'h0000, 1, 1'b0);

    // Backpressure on edge 1
    bp_exp = (TB_CLIP < 'h0380) ? 16'(TB_CLIP) : 16'h0380;
    bp_arm = 1'b1;
    stim = '{16'h0200, 16'hFF00, 16'h0080};
    run_node(16'h0100, 3, 1'b0);
    chk("bp_done", bp_arm, 0);

    // Degree zero
    stim.delete();
    expect_node(16'hFE00, 0);
    start_node(16'hFE00, 5'd0);
    @(negedge clk);
    chk("deg0_busy_sum", busy, 1);
    @(negedge clk);
    chk("deg0_busy_low", busy, 0);
    chk("deg0_bvld", belief_valid, 1);
    chk("deg0_no_vr", vr_valid, 0);
    @(negedge clk);
    chk("deg0_bvld_once", belief_valid, 0);
    wait_idle("deg0_idle");

    // Degree above DEG_MAX clamps to 16 accepted messages
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(16'(i * 37 - 200));
    n_acc = 0;
    run_node(16'h0040, 19, 1'b1);
    ch_valid = 1'b0;
    chk("deg_clamp_acc", n_acc, 16);

    // Reset in the middle of EMIT
    begin
      int g;
      stim = '{16'h0200, 16'hFF00, 16'h0080};
      expect_node(16'h0100, 3);
      start_node(16'h0100, 5'd3);
      feed(3, 1'b0);
      g = 0;
      do begin @(negedge clk); g++; end while (!(vr_valid && vr_ready) && g < 50);
      chk("rst_mid_reach_emit", vr_valid, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rstm_busy", busy, 0);
      chk("rstm_vr_valid", vr_valid, 0);
      chk("rstm_vr_msg", vr_msg, 0);
      chk("rstm_vr_idx", vr_idx, 0);
      chk("rstm_belief", belief, 0);
      chk("rstm_bvld", belief_valid, 0);
      chk("rstm_hard", hard_bit, 0);
      vq.delete();
      bq.delete();
      @(posedge clk); #1;
      rst = 1'b0;
    end
    stim = '{16'h0100};
    run_node(16'h0100, 1, 1'b0);

    // Random nodes
    for (int k = 0; k < 4; k++) begin
      int d;
      d = $urandom_range(1, 6);
      stim.delete();
      for (int i = 0; i < d; i++) stim.push_back(16'($urandom_range(0, 65535)));
      if (k == 1) stim[0] = 16'h8000;
      run_node(16'($urandom_range(0, 65535)), d, 1'b0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
